// File: rtl/pll_lock_sequencer.sv
// PLL lock qualification, system reset release and free-running clock enables.
// Runs on the PLL output clock; pll_locked is asynchronous and only enters via
// the synchroniser chain.
module pll_lock_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_HOLD   = 1024,
  parameter int unsigned CPU_DIV     = 6,
  parameter int unsigned AUX_DIV     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       sys_rst,
  output logic       ready,
  output logic       cen_cpu,
  output logic       cen_aux,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned HOLD_W = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD) : 1;
  localparam int unsigned CPU_W  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;
  localparam int unsigned AUX_W  = (AUX_DIV > 1) ? $clog2(AUX_DIV) : 1;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_RUN       = 2'd2
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_e                 state_q,    state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [CPU_W-1:0]       cpu_cnt_q,  cpu_cnt_d;
  logic [AUX_W-1:0]       aux_cnt_q,  aux_cnt_d;
  logic [CNT_W-1:0]       lost_cnt_q, lost_cnt_d;
  logic                   sys_rst_q,  sys_rst_d;
  logic                   ready_q,    ready_d;
  logic                   cen_cpu_q,  cen_cpu_d;
  logic                   cen_aux_q,  cen_aux_d;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Metastability synchroniser for the asynchronous PLL locked flag
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Next-state, hold counter, loss counter and registered output values
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lost_cnt_d = lost_cnt_q;
    cpu_cnt_d  = '0;
    aux_cnt_d  = '0;
    cen_cpu_d  = 1'b0;
    cen_aux_d  = 1'b0;

    unique case (state_q)
      ST_WAIT_LOCK: begin
        hold_cnt_d = '0;
        if (locked_s) begin
          state_d = ST_STABLE;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d    = ST_WAIT_LOCK;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_W'(LOCK_HOLD - 1)) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      ST_RUN: begin
        hold_cnt_d = '0;
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          if (lost_cnt_q != {CNT_W{1'b1}}) begin
            lost_cnt_d = lost_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d    = ST_WAIT_LOCK;
        hold_cnt_d = '0;
      end
    endcase

    // ready/sys_rst track the state being entered so they change with it
    ready_d   = (state_d == ST_RUN);
    sys_rst_d = (state_d != ST_RUN);

    // Divider counters hold the RUN cycle number modulo the divide ratio;
    // they sit at zero outside RUN so the phase restarts on every entry.
    if (state_d == ST_RUN) begin
      if (cpu_cnt_q == CPU_W'(CPU_DIV - 1)) begin
        cpu_cnt_d = '0;
        cen_cpu_d = 1'b1;
      end else begin
        cpu_cnt_d = cpu_cnt_q + CPU_W'(1);
      end
      if (aux_cnt_q == AUX_W'(AUX_DIV - 1)) begin
        aux_cnt_d = '0;
        cen_aux_d = 1'b1;
      end else begin
        aux_cnt_d = aux_cnt_q + AUX_W'(1);
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_WAIT_LOCK;
      hold_cnt_q <= '0;
      cpu_cnt_q  <= '0;
      aux_cnt_q  <= '0;
      lost_cnt_q <= '0;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      cen_cpu_q  <= 1'b0;
      cen_aux_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      cpu_cnt_q  <= cpu_cnt_d;
      aux_cnt_q  <= aux_cnt_d;
      lost_cnt_q <= lost_cnt_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      cen_cpu_q  <= cen_cpu_d;
      cen_aux_q  <= cen_aux_d;
    end
  end

  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign cen_cpu       = cen_cpu_q;
  assign cen_aux       = cen_aux_q;
  assign lock_lost_cnt = lost_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: window-based reference model of lock
// qualification, RUN-cycle numbering for the enables, loss counting.
module tb_pll_lock_sequencer;

  localparam int S  = 2;
  localparam int L  = 16;
  localparam int CD = 6;
  localparam int AD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       sys_rst;
  logic       ready;
  logic       cen_cpu;
  logic       cen_aux;
  logic [7:0] lock_lost_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  bit hist[$];        // pll_locked samples, index 0 = most recent edge
  int rst_age  = 0;   // consecutive edges with rst=0, including the latest
  int n_run    = 0;   // RUN cycle number (0 when not ready)
  int exp_cnt  = 0;
  bit exp_ready = 0;
  bit exp_cpu  = 0;
  bit exp_aux  = 0;

  pll_lock_sequencer #(
    .SYNC_STAGES(S),
    .LOCK_HOLD  (L),
    .CPU_DIV    (CD),
    .AUX_DIV    (AD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .cen_cpu      (cen_cpu),
    .cen_aux      (cen_aux),
    .lock_lost_cnt(lock_lost_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  function automatic logic [11:0] act_v();
    return {sys_rst, ready, cen_cpu, cen_aux, lock_lost_cnt};
  endfunction

  function automatic logic [11:0] exp_v();
    return {~exp_ready, exp_ready, exp_cpu, exp_aux, 8'(exp_cnt)};
  endfunction

  // One clock edge; model ready = no rst in the last S+L+1 edges and
  // pll_locked sampled high on each of the L+1 edges ending S edges ago.
  task automatic step();
    bit prev, ok;
    @(posedge clk);
    hist.push_front(pll_locked);
    if (hist.size() > S + L + 1) void'(hist.pop_back());
    rst_age = rst ? 0 : ((rst_age < 1000) ? rst_age + 1 : rst_age);
    ok = (rst_age >= S + L + 1);
    for (int i = S; i <= S + L; i++) if (!hist[i]) ok = 0;
    prev = exp_ready;
    exp_ready = ok;
    if (rst) exp_cnt = 0;
    else if (prev && !ok && exp_cnt < 255) exp_cnt++;
    n_run   = ok ? n_run + 1 : 0;
    exp_cpu = ok && (n_run % CD == 0);
    exp_aux = ok && (n_run % AD == 0);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pll_locked = 1'($urandom_range(0, 1));
      step();
      n_tests++;
      if (act_v() !== 12'h800) begin
        n_fail++;
        $display("FAIL reset_values cyc=%0d got=%h required=%h", i, act_v(), 12'h800);
      end
    end
    // Lock part-way into the hold window, then reset mid-STABLE
    rst = 1'b0;
    pll_locked = 1'b1;
    repeat (10) step();
    rst = 1'b1;
    step();
    n_tests++;
    if (act_v() !== 12'h800 || act_v() !== exp_v()) begin
      n_fail++;
      $display("FAIL reset_mid_stable got=%h required=%h", act_v(), 12'h800);
    end
    rst = 1'b0;
    pll_locked = 1'b0;
  endtask

  task automatic test_lockup();
    int first_rdy = -1, n = 0, first_cpu = 0, first_aux = 0;
    do_reset();
    repeat (3) step();
    pll_locked = 1'b1;
    for (int e = 0; e < 60; e++) begin
      step();
      n_tests++;
      if (act_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL lockup_model edge=%0d got=%h required=%h", e, act_v(), exp_v());
      end
      if (ready === 1'b1) begin
        if (first_rdy < 0) first_rdy = e;
        n++;
        if (cen_cpu === 1'b1 && first_cpu == 0) first_cpu = n;
        if (cen_aux === 1'b1 && first_aux == 0) first_aux = n;
        if (n == 12 || n == 24) begin
          n_tests++;
          if ({cen_cpu, cen_aux} !== 2'b11) begin
            n_fail++;
            $display("FAIL lockup_coincide n=%0d got=%b required=11", n, {cen_cpu, cen_aux});
          end
        end
      end
    end
    n_tests++;
    if (first_rdy != S + L) begin
      n_fail++;
      $display("FAIL lockup_latency got=%0d required=%0d", first_rdy, S + L);
    end
    n_tests++;
    if (first_cpu != CD || first_aux != AD) begin
      n_fail++;
      $display("FAIL lockup_first_cen got cpu=%0d aux=%0d required cpu=%0d aux=%0d",
               first_cpu, first_aux, CD, AD);
    end
  endtask

  task automatic test_stable_glitch();
    int rise = -1;
    do_reset();
    pll_locked = 1'b1;
    repeat (13) step();
    pll_locked = 1'b0;
    repeat (3) step();
    pll_locked = 1'b1;
    for (int e = 0; e < 60 && rise < 0; e++) begin
      step();
      n_tests++;
      if (act_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL glitch_model edge=%0d got=%h required=%h", e, act_v(), exp_v());
      end
      if (ready === 1'b1) rise = e;
    end
    n_tests++;
    if (rise != S + L || lock_lost_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL glitch_relock got rise=%0d cnt=%0d required rise=%0d cnt=0",
               rise, lock_lost_cnt, S + L);
    end
  endtask

  task automatic test_loss_in_run();
    int fall = -1, n = 0, first_cpu = 0;
    // Continue from the glitch test: currently RUN n=1
    repeat (6) step();
    pll_locked = 1'b0;
    for (int e = 0; e < 10; e++) begin
      step();
      n_tests++;
      if (act_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL loss_model edge=%0d got=%h required=%h", e, act_v(), exp_v());
      end
      if (fall < 0 && ready === 1'b0) fall = e;
    end
    n_tests++;
    if (fall != S || lock_lost_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL loss_fall got edge=%0d cnt=%0d required edge=%0d cnt=1", fall, lock_lost_cnt, S);
    end
    pll_locked = 1'b1;
    for (int e = 0; e < 80 && first_cpu == 0; e++) begin
      step();
      n_tests++;
      if (act_v() !== exp_v()) begin
        n_fail++;
        $display("FAIL relock_model edge=%0d got=%h required=%h", e, act_v(), exp_v());
      end
      if (ready === 1'b1) n++;
      if (cen_cpu === 1'b1) first_cpu = n;
    end
    n_tests++;
    if (first_cpu != CD) begin
      n_fail++;
      $display("FAIL relock_phase got n=%0d required n=%0d", first_cpu, CD);
    end
  endtask

  task automatic test_rst_with_loss();
    // In RUN with cnt=1; locked_s falls on the same edge rst is asserted
    pll_locked = 1'b0;
    repeat (S) step();
    rst = 1'b1;
    step();
    n_tests++;
    if (act_v() !== 12'h800 || act_v() !== exp_v()) begin
      n_fail++;
      $display("FAIL rst_wins got=%h required=%h", act_v(), 12'h800);
    end
    rst = 1'b0;
    step();
    n_tests++;
    if (lock_lost_cnt !== 8'd0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wins_after got cnt=%0d ready=%b required cnt=0 ready=0", lock_lost_cnt, ready);
    end
  endtask

  task automatic test_saturation();
    int bad = 0;
    do_reset();
    for (int k = 0; k < 260; k++) begin
      pll_locked = 1'b1;
      for (int e = 0; e < 40 && ready !== 1'b1; e++) begin
        step();
        n_tests++;
        if (act_v() !== exp_v()) begin
          n_fail++;
          bad++;
          if (bad < 10) $display("FAIL sat_model iter=%0d got=%h required=%h", k, act_v(), exp_v());
        end
      end
      n_tests++;
      if (ready !== 1'b1) begin
        n_fail++;
        $display("FAIL sat_lock_timeout iter=%0d got ready=%b required 1", k, ready);
      end
      pll_locked = 1'b0;
      repeat (S + 1) step();
    end
    n_tests++;
    if (lock_lost_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL saturation got=%0d required=255", lock_lost_cnt);
    end
  endtask

  task automatic test_long_run();
    int n_cpu = 0, n_aux = 0, n = 0, dbl = 0, bad = 0;
    bit prev_c = 0, prev_a = 0;
    do_reset();
    pll_locked = 1'b1;
    for (int e = 0; e < 60 && ready !== 1'b1; e++) step();
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++;
      $display("FAIL long_lock_timeout got ready=%b required 1", ready);
    end
    while (n < 10000) begin
      if (ready === 1'b1) n++;
      if (cen_cpu === 1'b1) n_cpu++;
      if (cen_aux === 1'b1) n_aux++;
      if ((prev_c && cen_cpu) || (prev_a && cen_aux)) dbl++;
      if (act_v() !== exp_v()) bad++;
      prev_c = cen_cpu;
      prev_a = cen_aux;
      if (n < 10000) step();
    end
    n_tests++;
    if (n_cpu != 1666 || n_aux != 2500) begin
      n_fail++;
      $display("FAIL long_counts got cpu=%0d aux=%0d required cpu=1666 aux=2500", n_cpu, n_aux);
    end
    n_tests++;
    if (dbl != 0 || bad != 0) begin
      n_fail++;
      $display("FAIL long_width got double=%0d model_diffs=%0d required 0 0", dbl, bad);
    end
  endtask

  task automatic test_random();
    int bad = 0, run = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        pll_locked = ~pll_locked;
        run = pll_locked ? $urandom_range(1, 45) : $urandom_range(1, 4);
      end
      run--;
      rst = ($urandom_range(0, 499) == 0);
      step();
      n_tests++;
      if (act_v() !== exp_v()) begin
        n_fail++;
        bad++;
        if (bad < 10) $display("FAIL random_model cyc=%0d got=%h required=%h", i, act_v(), exp_v());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b0;
    for (int i = 0; i < S + L + 1; i++) hist.push_back(1'b0);
    test_reset();
    test_lockup();
    test_stable_glitch();
    test_loss_in_run();
    test_rst_with_loss();
    test_saturation();
    test_long_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
